booth_mul_sequencer: RTL and testbench
======================================

// Module: booth_mul_sequencer
// PURPOSE
//  Upstream/downstream sequencer for the N-bit Booth multiplier (controller + datapath).
//  Accepts operand pairs on a valid/ready port and drives the multiplier's start pulse
//  with held operands. Captures the 2N-bit product on the multiplier's done pulse and
//  presents it on a valid/ready result port. One-entry operand skid slot; done watchdog.
// PARAMETERS
//  N        8        operand width (bits); product is 2N
//  TIMEOUT  2*N+8    max cycles from mul_start to mul_done before abort
//  CW       $clog2(TIMEOUT+1)  watchdog counter width (localparam)
// PORTS
//  clk          in   1    single clock; all state on posedge
//  rst          in   1    synchronous, active-high reset
//  in_valid     in   1    operand pair valid
//  in_ready     out  1    sequencer can accept operand pair
//  in_a         in   N    multiplicand (two's complement)
//  in_b         in   N    multiplier (two's complement)
//  res_valid    out  1    result valid
//  res_ready    in   1    consumer accepts result
//  res_p        out  2N   signed product {A,Q}
//  res_err      out  1    result is a timeout abort (res_p = 0)
//  mul_start    out  1    one-cycle start pulse to multiplier controller
//  mul_a        out  N    operand to M register, stable from mul_start until mul_done
//  mul_b        out  N    operand to Q register, same hold rule
//  mul_done     in   1    multiplier done (1-cycle pulse)
//  mul_product  in   2N   multiplier {A,Q}, valid in the mul_done cycle
//  busy         out  1    high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, res_valid=0, res_err=0, res_p=0, mul_start=0,
//   mul_a=mul_b=0, busy=0, skid slot empty, watchdog=0.
//  States:
//   IDLE:  on in_valid -> latch in_a/in_b into mul_a/mul_b -> ISSUE.
//   ISSUE: mul_start=1 for exactly this cycle; watchdog:=0 -> WAIT.
//   WAIT:  watchdog increments per cycle.
//          mul_done -> res_p:=mul_product, res_err:=0 -> OUT.
//          watchdog==TIMEOUT without done -> res_p:=0, res_err:=1 -> OUT.
//   OUT:   res_valid=1; res_p and res_err held until res_ready.
//          On res_valid&&res_ready:
//          - skid full  -> move skid to mul_a/mul_b, empty slot -> ISSUE;
//          - skid empty -> IDLE.
//  Operand hold: mul_a/mul_b change only when entering ISSUE.
//  in_ready = (state==IDLE) || !skid_full. Handshake occurs on in_valid&&in_ready.
//   In ISSUE/WAIT/OUT an accepted pair goes into the skid slot.
//  Latency: operand accept -> mul_start is 1 cycle.
//   mul_done -> res_valid is 1 cycle (registered).
//   Back-to-back: mul_start may fire the cycle after the result handshake.
//   The multiplier is in S0 by then.
//  Stray mul_done outside WAIT is ignored. A late done after a timeout is ignored.
//  Same-cycle done and watchdog==TIMEOUT: done wins.
//  Same-cycle result handshake and new operand accept with skid empty:
//   the pair bypasses the skid straight to mul_a/mul_b -> ISSUE.
//  Reset mid-operation: returns to IDLE immediately and drops the pending skid entry.
//   The multiplier has no reset; the multiplier must finish its run before the next
//   mul_start. After reset the sequencer holds in_ready=0 for TIMEOUT cycles.
//  Width: products are sign-correct 2N bits. No truncation.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE/ISSUE/WAIT/OUT),
//   TIMEOUT default formula.
//  Sub-module: booth_skid_slot (one-entry 2N-bit operand register, full flag,
//   push/pop, bypass).
//  Everything else (FSM, watchdog, result register) lives in this file.
// TESTING (N=8, bench uses the real controller+datapath plus a stub for timeouts)
//  in_a=3, in_b=-5 (8'hFB), res_ready=1 -> one mul_start; res_p=16'hFFF1; res_err=0.
//  (-128)*(-128) -> res_p=16'h4000; 0*x -> 0; 127*(-1) -> 16'hFF81.
//  Three pairs sent back-to-back, res_ready=0 during the first result -> in_ready drops
//   after skid fills; results come out in order; no operand lost.
//  Stub never asserts mul_done -> exactly TIMEOUT+1 cycles after mul_start:
//   res_valid=1, res_err=1, res_p=0; a later done pulse is ignored.
//  rst pulsed in WAIT -> next cycle all outputs at reset values; in_ready stays 0 for
//   TIMEOUT cycles; next op gives the correct product.
//  mul_done pulse injected in IDLE -> no state change; res_valid stays 0.

Source files
------------

// File: rtl/booth_mul_sequencer_pkg.sv
// Shared definitions for the Booth multiplier sequencer: FSM state encoding
// and the default done-watchdog limit.
package booth_mul_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // One Booth iteration per operand bit plus controller overhead and margin.
    function automatic int default_timeout(input int n);
        return 2 * n + 8;
    endfunction

endpackage

// File: rtl/booth_mul_sequencer_skid_slot.sv
// One-entry operand skid register. When empty, the output shows the incoming
// pair directly so a same-cycle pop can take it without storing it.
module booth_skid_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full
);

    logic [W-1:0] slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (pop) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end
    end

    // NOTE: payload storage carries no reset; the full flag alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (push && !pop && !full) begin
            slot <= din;
        end
    end

    assign dout = full ? slot : din;

endmodule

// File: rtl/booth_mul_sequencer.sv
// Valid/ready front end for the sequential Booth multiplier: issues held
// operands with a start pulse, captures the product on done, aborts on timeout.
module booth_mul_sequencer
    import booth_mul_sequencer_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = default_timeout(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] res_p,
    output logic           res_err,
    output logic           mul_start,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    input  logic           mul_done,
    input  logic [2*N-1:0] mul_product,
    output logic           busy
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    state_t          state;
    logic [CW-1:0]   watchdog;
    logic [CW-1:0]   watchdog_next;
    logic [CW-1:0]   holdoff;
    logic            skid_full;
    logic [2*N-1:0]  skid_dout;
    logic            accept;
    logic            res_fire;

    // The multiplier has no reset, so after our reset we wait out a full run.
    assign in_ready      = (holdoff == '0) && ((state == ST_IDLE) || !skid_full);
    assign accept        = in_valid && in_ready;
    assign res_fire      = res_valid && res_ready;
    assign watchdog_next = watchdog + 1'b1;

    booth_skid_slot #(
        .W(2 * N)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (accept && (state != ST_IDLE)),
        .pop  (res_fire),
        .din  ({in_a, in_b}),
        .dout (skid_dout),
        .full (skid_full)
    );

    // NOTE: every register here is state, so only non-blocking assignments are used.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_p     <= '0;
            busy      <= 1'b0;
            watchdog  <= '0;
            holdoff   <= TIMEOUT_C;
        end else begin
            mul_start <= 1'b0;
            if (holdoff != '0) begin
                holdoff <= holdoff - 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        {mul_a, mul_b} <= {in_a, in_b};
                        mul_start      <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    watchdog <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    watchdog <= watchdog_next;
                    // A done arriving on the timeout cycle still delivers its product.
                    if (mul_done) begin
                        res_p     <= mul_product;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (watchdog_next == TIMEOUT_C) begin
                        res_p     <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_fire) begin
                        res_valid <= 1'b0;
                        if (skid_full || accept) begin
                            {mul_a, mul_b} <= skid_dout;
                            mul_start      <= 1'b1;
                            state          <= ST_ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed bench for booth_mul_sequencer with a behavioural multiplier that
// can be switched to a silent stub for watchdog tests.
module tb_booth_mul_sequencer;

    localparam int N = 8;
    localparam int T = 2 * N + 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in_a = '0;
    logic [N-1:0]   in_b = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [2*N-1:0] res_p;
    logic           res_err;
    logic           mul_start;
    logic [N-1:0]   mul_a;
    logic [N-1:0]   mul_b;
    logic           mul_done;
    logic [2*N-1:0] mul_product;
    logic           busy;

    logic           stub = 1'b0;
    logic           model_done = 1'b0;
    logic [2*N-1:0] model_prod = '0;
    logic           stray_done = 1'b0;
    logic [2*N-1:0] stray_prod = '0;

    int tests = 0;
    int fails = 0;

    assign mul_done    = model_done | stray_done;
    assign mul_product = stray_done ? stray_prod : model_prod;

    always #5 clk = ~clk;

    booth_mul_sequencer #(.N(N), .TIMEOUT(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_p       (res_p),
        .res_err     (res_err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .busy        (busy)
    );

    // Behavioural multiplier: done pulse N cycles after start; no reset, like the real one.
    initial begin
        int cnt;
        logic signed [2*N-1:0] prod;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    model_done = 1'b1;
                    model_prod = prod;
                end
            end
            if (mul_start && !stub) begin
                cnt  = N;
                prod = $signed(mul_a) * $signed(mul_b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_holdoff(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, T);
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp, input string tag);
        int n;
        int starts;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        check({tag, " start"}, {mul_start, mul_a, mul_b}, {1'b1, a, b});
        starts = 0;
        n      = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
            if (mul_start) starts++;
        end
        check({tag, " result"}, {res_valid, res_err, res_p}, {1'b1, 1'b0, exp});
        check({tag, " starts"}, starts, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, " drained"}, res_valid, 1'b0);
    endtask

    logic [N-1:0]   ba[3] = '{8'd5, 8'hFE, 8'hFD};
    logic [N-1:0]   bb[3] = '{8'd6, 8'd7,  8'hFC};
    logic [2*N-1:0] bp[3] = '{16'h001E, 16'hFFF2, 16'h000C};

    initial begin
        int n;

        repeat (3) tick();
        check("rst_ctrl", {res_valid, res_err, mul_start, busy, in_ready}, 5'b0);
        check("rst_data", {res_p, mul_a, mul_b}, 32'h0);
        rst = 1'b0;
        count_holdoff("rst_holdoff");

        do_op(8'd3,   8'hFB, 16'hFFF1, "3x-5");
        do_op(8'h80,  8'h80, 16'h4000, "-128x-128");
        do_op(8'd0,   8'h5A, 16'h0000, "0x90");
        do_op(8'd127, 8'hFF, 16'hFF81, "127x-1");

        fork
            begin : sender
                int idx;
                int cyc;
                logic hs;
                idx = 0;
                cyc = 0;
                in_valid = 1'b1;
                while (idx < 3 && cyc < 300) begin
                    in_a = ba[idx];
                    in_b = bb[idx];
                    hs   = in_ready;
                    tick();
                    cyc++;
                    if (hs) begin
                        idx++;
                        if (idx == 2) check("skid_full_blocks", in_ready, 1'b0);
                    end
                end
                in_valid = 1'b0;
                check("b2b_all_sent", idx, 3);
            end
            begin : consumer
                logic [2*N-1:0] held;
                int w;
                for (int k = 0; k < 3; k++) begin
                    w = 0;
                    while (!res_valid && w < 300) begin
                        tick();
                        w++;
                    end
                    if (k == 0) begin
                        held = res_p;
                        repeat (4) tick();
                        check("b2b_held", {res_valid, res_p}, {1'b1, held});
                    end
                    check($sformatf("b2b_res%0d", k), {res_valid, res_err, res_p}, {1'b1, 1'b0, bp[k]});
                    res_ready = 1'b1;
                    tick();
                    res_ready = 1'b0;
                end
            end
        join
        tick();
        check("b2b_idle", {busy, res_valid}, 2'b00);

        stub     = 1'b1;
        in_valid = 1'b1;
        in_a     = 8'd7;
        in_b     = 8'd7;
        tick();
        in_valid = 1'b0;
        check("to_start", mul_start, 1'b1);
        n = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        check("to_latency", n, T + 1);
        check("to_result", {res_valid, res_err, res_p}, {1'b1, 1'b1, 16'h0000});
        stray_prod = 16'h1234;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        check("late_done_ignored", {res_valid, res_err, res_p}, {1'b1, 1'b1, 16'h0000});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        stub      = 1'b0;

        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        check("stray_idle", {res_valid, busy, mul_start}, 3'b000);

        in_valid = 1'b1;
        in_a     = 8'd9;
        in_b     = 8'd9;
        tick();
        in_a     = 8'd2;
        in_b     = 8'd2;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_ctrl", {res_valid, res_err, mul_start, busy, in_ready}, 5'b0);
        check("mid_rst_data", {res_p, mul_a, mul_b}, 32'h0);
        rst = 1'b0;
        count_holdoff("mid_rst_holdoff");
        do_op(8'hF9, 8'd9, 16'hFFC1, "-7x9");
        repeat (3) tick();
        check("skid_dropped", {res_valid, busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
